pipeline_hazard_ctrl: RTL

- Central stall/flush/freeze controller for the 5-stage RISC-V pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Handles three cases: load-use stalls, taken-branch flushes, and multi-cycle data-memory accesses via a req/ready handshake with timeout.
- Sits beside the pipeline registers; all inputs come from pipeline-register outputs and the data memory.

---
 rtl/pipeline_hazard_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze controller for the 5-stage pipeline: load-use stalls,
// taken-branch flushes and data-memory wait states with a timeout error.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_MemR,
  input  logic [4:0]       ex_RegDst,
  input  logic             ex_branch_taken,
  input  logic             mem_MemR,
  input  logic             mem_MemW,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic       err_set;
  logic       mem_acc;
  logic       lu_hit;
  logic       freeze;
  logic       apply_hz;

  assign mem_acc = mem_MemR | mem_MemW;
  assign lu_hit  = ex_MemR && (ex_RegDst != 5'd0) &&
                   ((id_rs1_used && (id_rs1 == ex_RegDst)) ||
                    (id_rs2_used && (id_rs2 == ex_RegDst)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (err_set) mem_err <= 1'b1;
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx     = state;
    wait_cnt_nx  = wait_cnt;
    err_set      = 1'b0;
    freeze       = 1'b0;
    apply_hz     = 1'b0;
    dmem_req     = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;

    unique case (state)
      RUN: begin
        dmem_req = mem_acc;
        if (mem_acc && !dmem_ready) begin
          freeze      = 1'b1;
          state_nx    = MEM_WAIT;
          wait_cnt_nx = 8'd1;
        end else begin
          apply_hz = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          apply_hz    = 1'b1;
          state_nx    = RUN;
          wait_cnt_nx = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt == TIMEOUT) begin
            state_nx = ERR;
            err_set  = 1'b1;
          end else begin
            wait_cnt_nx = wait_cnt + 8'd1;
          end
        end
      end
      ERR: freeze = 1'b1;
      default: state_nx = RUN;
    endcase

    if (freeze) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end

    // Branch wins over load-use; ID/EX keeps loading so the bubble enters EX.
    if (apply_hz) begin
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu_hit) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (rst) begin
      dmem_req     = 1'b0;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

endmodule
